// File: rtl/heavy_hash_streamer.sv
// Buffers 256-bit heavy-hash results in a DEPTH-entry FIFO and returns them to the
// comparator one 64-bit word per accepted request, little-endian word order.
module heavy_hash_streamer #(
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stop,
  input  logic [255:0]       hash_in,
  input  logic               hash_in_we,
  output logic               full,
  input  logic               heavy_hash_re,
  output logic [63:0]        heavy_hash_din,
  output logic               heavy_hash_din_we,
  output logic [LEVEL_W-1:0] fill_level,
  output logic [31:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [255:0]       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [1:0]         idx;
  logic [LEVEL_W-1:0] level_nxt;
  logic [255:0]       head;
  logic [63:0]        head_word;
  logic               push, drop, accept, pop;

  // full is the registered flag, so a push racing a freeing pop is still dropped
  assign push   = hash_in_we && !full && !stop;
  assign drop   = hash_in_we &&  full && !stop;
  // a word in flight blocks the next accept, limiting output to one word per 2 cycles
  assign accept = heavy_hash_re && (fill_level != '0) && !heavy_hash_din_we && !stop;
  assign pop    = accept && (idx == 2'd3);

  assign head      = mem[rd_ptr];
  assign head_word = head[idx*64 +: 64];

  always_comb begin
    level_nxt = fill_level;
    case ({push, pop})
      2'b10:   level_nxt = fill_level + LEVEL_W'(1);
      2'b01:   level_nxt = fill_level - LEVEL_W'(1);
      default: level_nxt = fill_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hash_in;
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      idx               <= '0;
      fill_level        <= '0;
      full              <= 1'b0;
      heavy_hash_din    <= '0;
      heavy_hash_din_we <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept) begin
        idx            <= idx + 2'd1;
        heavy_hash_din <= head_word;
      end
      heavy_hash_din_we <= accept;
      fill_level        <= level_nxt;
      full              <= (level_nxt == LEVEL_W'(DEPTH));
    end
  end

  // flush keeps the drop statistic; only reset clears it
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 32'hFFFF_FFFF)
      drop_cnt <= drop_cnt + 32'd1;
  end

endmodule

// File: tb/tb_heavy_hash_streamer.sv
// Directed bench for heavy_hash_streamer: streaming, empty retry, overflow, flush,
// and pop/push collision while full.
module tb_heavy_hash_streamer;

  localparam int DEPTH   = 4;
  localparam int LEVEL_W = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst, stop, hash_in_we, heavy_hash_re;
  logic [255:0]       hash_in;
  logic               full, heavy_hash_din_we;
  logic [63:0]        heavy_hash_din;
  logic [LEVEL_W-1:0] fill_level;
  logic [31:0]        drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  heavy_hash_streamer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stop(stop), .hash_in(hash_in), .hash_in_we(hash_in_we),
    .full(full), .heavy_hash_re(heavy_hash_re), .heavy_hash_din(heavy_hash_din),
    .heavy_hash_din_we(heavy_hash_din_we), .fill_level(fill_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [63:0] b);
    return {b + 64'd3, b + 64'd2, b + 64'd1, b};
  endfunction

  task automatic push(input logic [255:0] h);
    hash_in    = h;
    hash_in_we = 1'b1;
    tick();
    hash_in_we = 1'b0;
  endtask

  // waits (bounded) for the next response pulse and checks its word
  task automatic get_word(input logic [63:0] exp, input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (heavy_hash_din_we) break;
    end
    check({tag, "_we"}, 64'(heavy_hash_din_we), 64'd1);
    check(tag, heavy_hash_din, exp);
  endtask

  task automatic read_hash(input logic [255:0] h, input string tag);
    heavy_hash_re = 1'b1;
    for (int k = 0; k < 4; k++) get_word(h[64*k +: 64], tag);
    heavy_hash_re = 1'b0;
  endtask

  initial begin
    logic [255:0] h0;
    logic [63:0]  exp_din [8];
    logic         exp_we  [8];
    logic [63:0]  exp_lvl [8];
    h0 = {64'h4, 64'h3, 64'h2, 64'h1};
    exp_din = '{64'h1, 64'h1, 64'h2, 64'h2, 64'h3, 64'h3, 64'h4, 64'h4};
    exp_we  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_lvl = '{64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd0, 64'd0};

    rst = 1'b1; stop = 1'b0; hash_in_we = 1'b0; heavy_hash_re = 1'b0; hash_in = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_full",  64'(full), 64'd0);
    check("rst_we",    64'(heavy_hash_din_we), 64'd0);
    check("rst_din",   heavy_hash_din, 64'd0);
    check("rst_level", 64'(fill_level), 64'd0);
    check("rst_drop",  drop_cnt, 64'd0);

    // 1: single hash streamed with re held high
    push(h0);
    check("t1_level_push", 64'(fill_level), 64'd1);
    heavy_hash_re = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("t1_we_c%0d", c),    64'(heavy_hash_din_we), 64'(exp_we[c]));
      check($sformatf("t1_din_c%0d", c),   heavy_hash_din, exp_din[c]);
      check($sformatf("t1_level_c%0d", c), 64'(fill_level), exp_lvl[c]);
    end
    heavy_hash_re = 1'b0;

    // 2: requests against empty FIFO are ignored, then push while requesting
    heavy_hash_re = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t2_empty_we", 64'(heavy_hash_din_we), 64'd0);
    end
    push(h0);
    check("t2_push_we", 64'(heavy_hash_din_we), 64'd0);
    tick();
    check("t2_first_we",  64'(heavy_hash_din_we), 64'd1);
    check("t2_first_din", heavy_hash_din, 64'h1);
    get_word(64'h2, "t2_w1");
    get_word(64'h3, "t2_w2");
    get_word(64'h4, "t2_w3");
    heavy_hash_re = 1'b0;
    tick();
    check("t2_level_end", 64'(fill_level), 64'd0);

    // 3: overflow by two, first DEPTH come back in order
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(mk(64'h100 * (i + 1)));
      if (i == DEPTH - 2) check("t3_notfull", 64'(full), 64'd0);
      if (i == DEPTH - 1) check("t3_full", 64'(full), 64'd1);
    end
    check("t3_drop",  drop_cnt, 64'd2);
    check("t3_level", 64'(fill_level), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) read_hash(mk(64'h100 * (i + 1)), $sformatf("t3_h%0d", i));
    tick();
    check("t3_level_end", 64'(fill_level), 64'd0);
    check("t3_full_end",  64'(full), 64'd0);

    // 4: flush mid-hash with another hash queued
    push(mk(64'h1000));
    push(mk(64'h2000));
    heavy_hash_re = 1'b1;
    get_word(64'h1000, "t4_w0");
    get_word(64'h1001, "t4_w1");
    tick();
    stop = 1'b1;
    tick();
    check("t4_stop_we",    64'(heavy_hash_din_we), 64'd0);
    check("t4_stop_level", 64'(fill_level), 64'd0);
    check("t4_stop_full",  64'(full), 64'd0);
    check("t4_stop_drop",  drop_cnt, 64'd2);
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4_after_we", 64'(heavy_hash_din_we), 64'd0);
    end
    heavy_hash_re = 1'b0;
    push(mk(64'h3000));
    read_hash(mk(64'h3000), "t4_h2");

    // 6: pop of the last word coincides with a push while full
    for (int i = 0; i < DEPTH; i++) push(mk(64'h10000 * (i + 1)));
    check("t6_full", 64'(full), 64'd1);
    heavy_hash_re = 1'b1;
    get_word(64'h10000, "t6_w0");
    get_word(64'h10001, "t6_w1");
    get_word(64'h10002, "t6_w2");
    tick();
    hash_in    = mk(64'hBEEF00);
    hash_in_we = 1'b1;
    tick();
    hash_in_we    = 1'b0;
    heavy_hash_re = 1'b0;
    check("t6_w3_we",  64'(heavy_hash_din_we), 64'd1);
    check("t6_w3",     heavy_hash_din, 64'h10003);
    check("t6_drop",   drop_cnt, 64'd3);
    check("t6_level",  64'(fill_level), 64'(DEPTH - 1));
    check("t6_nofull", 64'(full), 64'd0);
    tick();
    check("t6_level_hold", 64'(fill_level), 64'(DEPTH - 1));
    for (int i = 1; i < DEPTH; i++) read_hash(mk(64'h10000 * (i + 1)), $sformatf("t6_h%0d", i));
    tick();
    check("t6_level_end", 64'(fill_level), 64'd0);

    // reset clears the drop counter that stop preserved
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_drop", drop_cnt, 64'd0);
    check("rst2_din",  heavy_hash_din, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
